// File: rtl/spin_update_controller.sv
// ---------------------------------------------------------------------------
// spin_update_controller
//
// Sequential Gauss-Seidel spin-update engine. It holds the spin vector,
// fetches one J column per step over a valid/ready request/response channel,
// presents spins plus the diagonal-masked column to an external combinational
// dot-product tree, reads the local field back and writes the new spin bit.
// Columns 0..N-1 are swept repeatedly until a sweep produces no flips or the
// sweep limit is reached.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              start pulse, accepted only in IDLE
//   sigma_init_i         initial spins, captured on start
//   num_sweeps_i         sweep limit, captured on start
//   col_req_valid_o/col_req_ready_i/col_idx_o   column request channel
//   J_col_valid_i/J_col_ready_o/J_col_i         column data channel
//   sigma_o, J_col_o     registered operands for the tree
//   dot_i                signed local field from the tree
//   busy_o, done_o, converged_o, sweep_cnt_o, flips_o   status
// ---------------------------------------------------------------------------
module spin_update_controller #(
    parameter int VECTOR_SIZE      = 256,
    parameter int J_ELEMENT_WIDTH  = 4,
    parameter int SWEEP_WIDTH      = 16,
    localparam int INT_RESULT_WIDTH = J_ELEMENT_WIDTH + $clog2(VECTOR_SIZE) + 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   start_i,
    input  logic [VECTOR_SIZE-1:0]                 sigma_init_i,
    input  logic [SWEEP_WIDTH-1:0]                 num_sweeps_i,
    output logic                                   col_req_valid_o,
    input  logic                                   col_req_ready_i,
    output logic [$clog2(VECTOR_SIZE)-1:0]         col_idx_o,
    input  logic                                   J_col_valid_i,
    output logic                                   J_col_ready_o,
    input  logic [VECTOR_SIZE*J_ELEMENT_WIDTH-1:0] J_col_i,
    output logic [VECTOR_SIZE-1:0]                 sigma_o,
    output logic [VECTOR_SIZE*J_ELEMENT_WIDTH-1:0] J_col_o,
    input  logic [INT_RESULT_WIDTH-1:0]            dot_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   converged_o,
    output logic [SWEEP_WIDTH-1:0]                 sweep_cnt_o,
    output logic [$clog2(VECTOR_SIZE):0]           flips_o
);

    localparam int IW = $clog2(VECTOR_SIZE);
    localparam int FW = IW + 1;
    localparam int JW = J_ELEMENT_WIDTH;
    localparam logic [IW-1:0] LAST_IDX = IW'(VECTOR_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        EVAL  = 3'd3,
        SWEND = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                        state_r;
    state_t                        state_next_s;
    logic [SWEEP_WIDTH-1:0]        sweep_limit_r;
    logic [SWEEP_WIDTH-1:0]        sweep_inc_s;
    logic                          limit_hit_s;
    logic                          new_bit_s;
    logic                          flip_s;
    logic [VECTOR_SIZE*JW-1:0]     masked_col_s;

    // Sweep bookkeeping: the count after this sweep and whether it hits the limit.
    always_comb begin
        sweep_inc_s = sweep_cnt_o + {{(SWEEP_WIDTH-1){1'b0}}, 1'b1};
        limit_hit_s = (sweep_inc_s >= sweep_limit_r);
    end

    // Spin decision from the signed field; a zero field keeps the current spin.
    always_comb begin
        new_bit_s = sigma_o[col_idx_o];
        if (dot_i[INT_RESULT_WIDTH-1]) begin
            new_bit_s = 1'b0;
        end else if (dot_i != {INT_RESULT_WIDTH{1'b0}}) begin
            new_bit_s = 1'b1;
        end else begin
            new_bit_s = sigma_o[col_idx_o];
        end
        flip_s = (new_bit_s != sigma_o[col_idx_o]);
    end

    // Incoming column with the self-coupling element of the current column zeroed.
    always_comb begin
        masked_col_s = J_col_i;
        for (int k = 0; k < VECTOR_SIZE; k++) begin
            if (k == int'(col_idx_o)) begin
                masked_col_s[k*JW +: JW] = {JW{1'b0}};
            end else begin
                masked_col_s[k*JW +: JW] = J_col_i[k*JW +: JW];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    if (num_sweeps_i == {SWEEP_WIDTH{1'b0}}) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = REQ;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (col_req_ready_i) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (J_col_valid_i) begin
                    state_next_s = EVAL;
                end else begin
                    state_next_s = WAIT;
                end
            end
            EVAL: begin
                if (col_idx_o == LAST_IDX) begin
                    state_next_s = SWEND;
                end else begin
                    state_next_s = REQ;
                end
            end
            SWEND: begin
                if (flips_o == {FW{1'b0}}) begin
                    state_next_s = DONE;
                end else if (limit_hit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = REQ;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered status outputs; handshake outputs track the next state
    // so they are registered yet coincide with the state they belong to.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_req_valid_o <= 1'b0;
            J_col_ready_o   <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            converged_o     <= 1'b0;
            col_idx_o       <= {IW{1'b0}};
            sigma_o         <= {VECTOR_SIZE{1'b0}};
            J_col_o         <= {(VECTOR_SIZE*JW){1'b0}};
            sweep_cnt_o     <= {SWEEP_WIDTH{1'b0}};
            sweep_limit_r   <= {SWEEP_WIDTH{1'b0}};
            flips_o         <= {FW{1'b0}};
        end else begin
            col_req_valid_o <= (state_next_s == REQ);
            J_col_ready_o   <= (state_next_s == WAIT);
            busy_o          <= (state_next_s != IDLE);
            done_o          <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        sigma_o       <= sigma_init_i;
                        sweep_limit_r <= num_sweeps_i;
                        col_idx_o     <= {IW{1'b0}};
                        sweep_cnt_o   <= {SWEEP_WIDTH{1'b0}};
                        flips_o       <= {FW{1'b0}};
                        converged_o   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (J_col_valid_i) begin
                        J_col_o <= masked_col_s;
                    end
                end
                EVAL: begin
                    if (flip_s) begin
                        sigma_o[col_idx_o] <= new_bit_s;
                        flips_o            <= flips_o + {{(FW-1){1'b0}}, 1'b1};
                    end
                    if (col_idx_o != LAST_IDX) begin
                        col_idx_o <= col_idx_o + {{(IW-1){1'b0}}, 1'b1};
                    end
                end
                SWEND: begin
                    sweep_cnt_o <= sweep_inc_s;
                    col_idx_o   <= {IW{1'b0}};
                    if (flips_o == {FW{1'b0}}) begin
                        converged_o <= 1'b1;
                    end else if (limit_hit_s) begin
                        converged_o <= 1'b0;
                    end else begin
                        flips_o <= {FW{1'b0}};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spin_update_controller.sv
// ---------------------------------------------------------------------------
// Testbench for spin_update_controller with N=4, JW=4. The bench models the
// combinational dot-product tree and a zero-latency column memory whose
// off-diagonal and diagonal element values are selectable. Expected results
// per run are pushed into a scoreboard queue; a monitor pops and compares
// whenever done_o is presented.
// ---------------------------------------------------------------------------
module tb_spin_update_controller;

    localparam int N  = 4;
    localparam int JW = 4;
    localparam int SW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [N-1:0]  sigma_init_i;
    logic [SW-1:0] num_sweeps_i;
    logic          col_req_valid_o;
    logic          col_req_ready_i;
    logic [1:0]    col_idx_o;
    logic          J_col_valid_i;
    logic          J_col_ready_o;
    logic [N*JW-1:0] J_col_i;
    logic [N-1:0]  sigma_o;
    logic [N*JW-1:0] J_col_o;
    logic [6:0]    dot_i;
    logic          busy_o;
    logic          done_o;
    logic          converged_o;
    logic [SW-1:0] sweep_cnt_o;
    logic [2:0]    flips_o;

    typedef struct {
        logic          conv;
        logic [SW-1:0] sw;
        logic [N-1:0]  sig;
        logic [2:0]    fl;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic stall_mode = 1'b0;
    logic [JW-1:0] j_off  = 4'd0;
    logic [JW-1:0] j_diag = 4'd0;

    always #5 clk_i = ~clk_i;

    spin_update_controller #(
        .VECTOR_SIZE     (N),
        .J_ELEMENT_WIDTH (JW),
        .SWEEP_WIDTH     (SW)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .sigma_init_i    (sigma_init_i),
        .num_sweeps_i    (num_sweeps_i),
        .col_req_valid_o (col_req_valid_o),
        .col_req_ready_i (col_req_ready_i),
        .col_idx_o       (col_idx_o),
        .J_col_valid_i   (J_col_valid_i),
        .J_col_ready_o   (J_col_ready_o),
        .J_col_i         (J_col_i),
        .sigma_o         (sigma_o),
        .J_col_o         (J_col_o),
        .dot_i           (dot_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .converged_o     (converged_o),
        .sweep_cnt_o     (sweep_cnt_o),
        .flips_o         (flips_o)
    );

    // Dot-product tree model: sum of +J or -J per spin.
    always_comb begin
        int acc;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            if (sigma_o[k]) acc = acc + int'(J_col_o[k*JW +: JW]);
            else            acc = acc - int'(J_col_o[k*JW +: JW]);
        end
        dot_i = 7'(acc);
    end

    // Column memory: element k of column c is j_diag when k == c, else j_off.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            J_col_i[k*JW +: JW] = (k == int'(col_idx_o)) ? j_diag : j_off;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},      32'(busy_o), 32'd0);
        chk({tag, "_done"},      32'(done_o), 32'd0);
        chk({tag, "_conv"},      32'(converged_o), 32'd0);
        chk({tag, "_reqv"},      32'(col_req_valid_o), 32'd0);
        chk({tag, "_jrdy"},      32'(J_col_ready_o), 32'd0);
        chk({tag, "_idx"},       32'(col_idx_o), 32'd0);
        chk({tag, "_sigma"},     32'(sigma_o), 32'd0);
        chk({tag, "_jcol"},      32'(J_col_o), 32'd0);
        chk({tag, "_sweeps"},    32'(sweep_cnt_o), 32'd0);
        chk({tag, "_flips"},     32'(flips_o), 32'd0);
    endtask

    // Monitor: compare the completed run against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (done_o) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done_o=1, expected no completion (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_converged", 32'(converged_o), 32'(e.conv));
                    chk("sb_sweep_cnt", 32'(sweep_cnt_o), 32'(e.sw));
                    chk("sb_sigma",     32'(sigma_o),     32'(e.sig));
                    chk("sb_flips",     32'(flips_o),     32'(e.fl));
                end
            end
        end
    end

    // Column channel responder: zero latency, or stalling request 5 cycles
    // and data 3 cycles per column while checking that the DUT holds still.
    initial begin
        int         req_cnt = 0;
        int         dat_cnt = 0;
        logic       rstall_prev = 1'b0;
        logic       dstall_prev = 1'b0;
        logic [1:0] idx_hold = 2'd0;
        col_req_ready_i = 1'b0;
        J_col_valid_i   = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!stall_mode) begin
                col_req_ready_i = 1'b1;
                J_col_valid_i   = 1'b1;
                rstall_prev     = 1'b0;
                dstall_prev     = 1'b0;
                req_cnt         = 0;
                dat_cnt         = 0;
            end else begin
                if (rstall_prev) begin
                    chk("req_valid_held", 32'(col_req_valid_o), 32'd1);
                    chk("req_idx_held",   32'(col_idx_o),       32'(idx_hold));
                end
                if (dstall_prev) chk("no_eval_before_data", 32'(J_col_ready_o), 32'd1);
                if (col_req_valid_o) begin
                    if (req_cnt == 0) idx_hold = col_idx_o;
                    col_req_ready_i = (req_cnt >= 5);
                    rstall_prev     = (req_cnt < 5);
                    req_cnt++;
                end else begin
                    col_req_ready_i = 1'b0;
                    rstall_prev     = 1'b0;
                    req_cnt         = 0;
                end
                if (J_col_ready_o) begin
                    J_col_valid_i = (dat_cnt >= 3);
                    dstall_prev   = (dat_cnt < 3);
                    dat_cnt++;
                end else begin
                    J_col_valid_i = 1'b0;
                    dstall_prev   = 1'b0;
                    dat_cnt       = 0;
                end
            end
        end
    end

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done_o && cyc < 5000) begin
            @(negedge clk_i);
            cyc++;
        end
        if (!done_o) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done_o, expected done within 5000 cycles");
        end else begin
            @(negedge clk_i);
            chk("done_one_cycle", 32'(done_o), 32'd0);
        end
    endtask

    task automatic run(input logic [JW-1:0] off, input logic [JW-1:0] diag,
                       input logic [N-1:0] init, input logic [SW-1:0] ns,
                       input exp_t e, output int cyc);
        j_off  = off;
        j_diag = diag;
        @(negedge clk_i);
        sigma_init_i = init;
        num_sweeps_i = ns;
        start_i      = 1'b1;
        sb_q.push_back(e);
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(cyc);
    endtask

    initial begin
        int cyc;
        int dn;
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        sigma_init_i = 4'b0000;
        num_sweeps_i = 16'd0;
        repeat (3) @(negedge clk_i);
        chk_zero("rst");
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk_zero("idle");

        // All J=1, all spins down: fields -3, converges in one sweep, 3N+1 cycles.
        run(4'd1, 4'd1, 4'b0000, 16'd8, '{1'b1, 16'd1, 4'b0000, 3'd0}, cyc);
        chk("latency_1sweep", 32'(cyc), 32'd13);
        // All J=1 from 0111: spin 3 flips in sweep 1, sweep 2 clean.
        run(4'd1, 4'd1, 4'b0111, 16'd8, '{1'b1, 16'd2, 4'b1111, 3'd0}, cyc);
        // Sweep limit 1 stops after the flipping sweep.
        run(4'd1, 4'd1, 4'b0111, 16'd1, '{1'b0, 16'd1, 4'b1111, 3'd1}, cyc);
        // Large diagonal must be masked, otherwise spin 3 would not flip.
        run(4'd1, 4'd15, 4'b0111, 16'd8, '{1'b1, 16'd2, 4'b1111, 3'd0}, cyc);
        // All J=0: ties keep spins.
        run(4'd0, 4'd0, 4'b1010, 16'd8, '{1'b1, 16'd1, 4'b1010, 3'd0}, cyc);
        // Zero sweep limit: done right after start.
        run(4'd0, 4'd0, 4'b1010, 16'd0, '{1'b0, 16'd0, 4'b1010, 3'd0}, cyc);
        chk("latency_zero_sweeps", 32'(cyc), 32'd0);
        chk("hold_after_done_sigma", 32'(sigma_o), 32'b1010);

        // Stalled channel must give the same result as the unstalled run.
        stall_mode = 1'b1;
        run(4'd1, 4'd1, 4'b0111, 16'd8, '{1'b1, 16'd2, 4'b1111, 3'd0}, cyc);
        stall_mode = 1'b0;
        repeat (2) @(negedge clk_i);

        // Reset asynchronously while waiting for column data in sweep 1.
        j_off  = 4'd1;
        j_diag = 4'd1;
        sigma_init_i = 4'b0111;
        num_sweeps_i = 16'd8;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc = 0;
        while (!J_col_ready_o && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("reached_wait", 32'(J_col_ready_o), 32'd1);
        chk("pre_reset_sigma", 32'(sigma_o), 32'b0111);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_zero("async_rst");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (done_o) dn++;
        end
        chk("no_done_after_reset", 32'(dn), 32'd0);

        // Fresh run with a start pulse mid-run that must be ignored.
        @(negedge clk_i);
        sigma_init_i = 4'b0111;
        num_sweeps_i = 16'd8;
        start_i      = 1'b1;
        sb_q.push_back('{1'b1, 16'd2, 4'b1111, 3'd0});
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        sigma_init_i = 4'b0000;
        num_sweeps_i = 16'd0;
        start_i      = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(cyc);

        repeat (3) @(negedge clk_i);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
